mpg_sd_arbiter: RTL

Two-requester arbiter and sequencer for the single hps_io sd_* sector-read channel in the MPEG2 player. It sits between hps_io and two sector clients (port 0 is the video-stream sector streamer; port 1 is a secondary reader, such as an index, seek or audio fetcher). It grants the channel to one requester at a time using round-robin, and holds the grant for the whole sector transfer. It routes only the ack and write strobes to the granted side, and recovers from an HPS that never acknowledges a request.

---
 rtl/mpg_sd_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/mpg_sd_arbiter.sv
// mpg_sd_arbiter: round-robin arbiter and sequencer for the shared hps_io sd_* sector-read channel
module mpg_sd_arbiter #(
  parameter logic [31:0] TIMEOUT     = 32'd0,
  parameter int          ABORT_QUIET = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req0_lba,
  input  logic [31:0] req1_lba,
  input  logic        req0_rd,
  input  logic        req1_rd,
  output logic        req0_ack,
  output logic        req1_ack,
  output logic        req0_buff_wr,
  output logic        req1_buff_wr,
  output logic        req0_err,
  output logic        req1_err,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic        grant,
  output logic        busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;
  localparam logic [31:0] TO_LAST    = TIMEOUT - 32'd1;
  localparam logic [31:0] QUIET_LAST = 32'(ABORT_QUIET - 1);
  logic [1:0]  state;
  logic        last_grant;
  logic [31:0] cnt;
  logic        ack_q;
  logic        route;
  logic        sel;
  // Strobes reach only the owner, and only while its request is live; ABORT swallows a late ack
  always_comb begin
    route        = (state == ISSUE) || (state == XFER);
    sel          = (req0_rd && req1_rd) ? ~last_grant : req1_rd;
    req0_ack     = sd_ack & route & ~grant;
    req1_ack     = sd_ack & route & grant;
    req0_buff_wr = sd_buff_wr & route & ~grant;
    req1_buff_wr = sd_buff_wr & route & grant;
    busy         = state != IDLE;
  end
  // Channel sequencer: grant, hold through the transfer, watchdog abort and quiet-period recovery
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      sd_lba     <= 32'd0;
      sd_rd      <= 1'b0;
      cnt        <= 32'd0;
      ack_q      <= 1'b0;
      req0_err   <= 1'b0;
      req1_err   <= 1'b0;
    end else begin
      ack_q    <= sd_ack;
      req0_err <= 1'b0;
      req1_err <= 1'b0;
      case (state)
        IDLE: if (!sd_ack && (req0_rd || req1_rd)) begin
          sd_lba <= sel ? req1_lba : req0_lba;
          sd_rd  <= 1'b1;
          grant  <= sel;
          cnt    <= 32'd0;
          state  <= ISSUE;
        end
        ISSUE: begin
          cnt <= cnt + 32'd1;
          if (sd_ack) begin
            sd_rd <= 1'b0;
            state <= XFER;
          end else if (TIMEOUT != 32'd0 && cnt == TO_LAST) begin
            sd_rd    <= 1'b0;
            req0_err <= ~grant;
            req1_err <= grant;
            cnt      <= 32'd0;
            state    <= ABORT;
          end
        end
        XFER: if (ack_q && !sd_ack) begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: if (sd_ack) cnt <= 32'd0;
        else if (cnt == QUIET_LAST) begin
          last_grant <= grant;
          state      <= IDLE;
        end else cnt <= cnt + 32'd1;
      endcase
    end
  end
endmodule
